clock_timekeeper: RTL and testbench
===================================

Name: clock_timekeeper

Overview:
Free-running 24-hour BCD timekeeper. It produces the hour/minute digit bus that the 4-digit multiplexed seven-segment display driver consumes. A parameterised prescaler derives a 1 Hz tick from the board clock. Two push-buttons let the user set hours and minutes.

Parameters:
TICKS_PER_SEC, 100000000, clk cycles per second; minimum 2 (benches use 4)
CNT_W, 27, prescaler width; must satisfy 2**CNT_W >= TICKS_PER_SEC

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (0 = reset)
run  input  1  1 = time advances; 0 = prescaler and seconds frozen, buttons still work
btn_hour  input  1  raw asynchronous button, hour increment
btn_min  input  1  raw asynchronous button, minute increment
hour1  output  2  BCD hour tens, 0..2
hour0  output  4  BCD hour units, 0..9 (0..3 when hour1==2)
min1  output  3  BCD minute tens, 0..5
min0  output  4  BCD minute units, 0..9
sec_tick  output  1  one-cycle pulse per elapsed second
blink  output  1  1 for the first half of each second (colon/dot blink)

Behaviour:
- Reset (rst low, async): all digits 0 (00:00); seconds 0; prescaler 0; sec_tick 0; blink 1; synchronisers and edge registers 0. All outputs are registered.
- Prescaler pcnt:
  - Counts 0..TICKS_PER_SEC-1 while run=1, holds while run=0.
  - At pcnt==TICKS_PER_SEC-1 with run=1: wraps to 0 and sec_tick=1 in the next cycle.
  - blink = (pcnt < TICKS_PER_SEC/2), integer division, registered.
- Seconds sec, 6-bit binary 0..59:
  - Increments on the internal tick strobe; 59 -> 0 generates min_carry in the same cycle.
- Minutes: BCD increment on min_carry.
  - min0 9 -> 0 carries into min1.
  - 59 -> 00 generates hour_carry.
- Hours: BCD increment on hour_carry.
  - hour0 9 -> 0 carries into hour1.
  - 23 -> 00 wraps with no further carry.
- Buttons:
  - Each button passes a 2-FF synchroniser, then a rising-edge detector against a third register, giving a one-cycle pulse inc_h / inc_m.
  - Holding a button yields exactly one increment.
  - Latency: button rising before clk edge k gives the updated digits visible after edge k+3.
- inc_m: minutes +1 with wrap 59 -> 00 and no hour carry; seconds cleared to 0; the prescaler is not touched.
- inc_h: hours +1 with wrap 23 -> 00; minutes and seconds untouched.
- Simultaneous events (same cycle):
  - inc_m with min_carry: minutes advance by exactly 1, seconds become 0, and that min_carry produces no hour_carry.
  - inc_h with hour_carry: hours advance by exactly 1.
  - inc_h with inc_m: both applied independently per the two rules above.
- Digits never leave legal BCD ranges. No illegal state is reachable from reset.
- run=0 mid-second: pcnt holds its value; resumes from that value when run returns to 1.
- Reset mid-operation: immediate return to 00:00 and pcnt 0. The first sec_tick occurs TICKS_PER_SEC cycles after rst deasserts (with run=1).

Decomposition:
- Shared package clock_pkg:
  - BCD limits: MIN0_MAX=9, MIN1_MAX=5, HOUR0_MAX=9, HOUR0_MAX_AT_2=3, HOUR1_MAX=2, SEC_MAX=59.
  - Digit widths: 2/4/3/4.
- One natural sub-module: tick_prescaler (TICKS_PER_SEC, CNT_W; ports clk, rst, run, tick, blink).
- Button synchroniser/edge detect stays inline, instantiated twice via generate or duplicated.

Test Plan:
- TICKS_PER_SEC=4, run=1 from reset, 240 cycles -> digits 00:01, sec_tick pulsed 60 times, each pulse 1 cycle, 4 cycles apart, first at cycle 4 after rst release.
- Preset 23:59 via buttons, then run 60 s -> rolls to 00:00 on the 60th tick, no intermediate illegal value (e.g. 24:00).
- Time 12:34 with sec=59, pulse btn_min timed so inc_m hits the same cycle as the tick -> 12:35 (not 12:36), seconds 0.
- Time 09:59 at sec=59, pulse btn_hour timed so inc_h coincides with hour_carry -> 10:00; btn_hour held 100 cycles -> exactly one increment.
- run=0 for 50 cycles at pcnt=2 -> no sec_tick, digits and pcnt frozen; run=1 -> next sec_tick after 2 more cycles.
- Assert rst low asynchronously between clock edges at 17:42 -> outputs 00:00 before the next clk edge; blink=1, sec_tick=0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared BCD limits, digit widths and digit-increment helpers for the 24-hour timekeeper.
package clock_pkg;

  localparam int unsigned HOUR1_W = 2;
  localparam int unsigned HOUR0_W = 4;
  localparam int unsigned MIN1_W  = 3;
  localparam int unsigned MIN0_W  = 4;
  localparam int unsigned SEC_W   = 6;

  localparam logic [MIN0_W-1:0]  MIN0_MAX       = 4'd9;
  localparam logic [MIN1_W-1:0]  MIN1_MAX       = 3'd5;
  localparam logic [HOUR0_W-1:0] HOUR0_MAX      = 4'd9;
  localparam logic [HOUR0_W-1:0] HOUR0_MAX_AT_2 = 4'd3;
  localparam logic [HOUR1_W-1:0] HOUR1_MAX      = 2'd2;
  localparam logic [SEC_W-1:0]   SEC_MAX        = 6'd59;

  typedef struct packed {
    logic [HOUR1_W-1:0] hour1;
    logic [HOUR0_W-1:0] hour0;
    logic [MIN1_W-1:0]  min1;
    logic [MIN0_W-1:0]  min0;
  } bcd_time_t;

  function automatic logic min_at_max(bcd_time_t t);
    return (t.min1 == MIN1_MAX) && (t.min0 == MIN0_MAX);
  endfunction

  // Minutes +1 with 59 -> 00 wrap; hours are left alone.
  function automatic bcd_time_t inc_min(bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.min0 == MIN0_MAX) begin
      r.min0 = '0;
      r.min1 = (t.min1 == MIN1_MAX) ? '0 : t.min1 + 3'd1;
    end else begin
      r.min0 = t.min0 + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd_time_t inc_hour(bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.hour1 == HOUR1_MAX && t.hour0 == HOUR0_MAX_AT_2) begin
      r.hour1 = '0;
      r.hour0 = '0;
    end else if (t.hour0 == HOUR0_MAX) begin
      r.hour0 = '0;
      r.hour1 = t.hour1 + 2'd1;
    end else begin
      r.hour0 = t.hour0 + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/clock_timekeeper_if.sv
// Control inputs and display-facing outputs of the timekeeper.
interface clock_timekeeper_if;
  import clock_pkg::*;

  logic               run;
  logic               btn_hour;
  logic               btn_min;
  logic [HOUR1_W-1:0] hour1;
  logic [HOUR0_W-1:0] hour0;
  logic [MIN1_W-1:0]  min1;
  logic [MIN0_W-1:0]  min0;
  logic               sec_tick;
  logic               blink;

  modport master (
    output run, btn_hour, btn_min,
    input  hour1, hour0, min1, min0, sec_tick, blink
  );

  modport slave (
    input  run, btn_hour, btn_min,
    output hour1, hour0, min1, min0, sec_tick, blink
  );
endinterface

// File: rtl/tick_prescaler.sv
// Divides the board clock down to a once-per-second strobe and a 50% blink flag.
module tick_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick,
  output logic blink
);

  localparam logic [CNT_W-1:0] Last = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] Half = CNT_W'(TICKS_PER_SEC / 2);

  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             blink_q;

  // Combinational strobe: the top registers it so digits and sec_tick change together.
  assign tick  = run && (pcnt_q == Last);
  assign blink = blink_q;

  always_comb begin
    pcnt_d = pcnt_q;
    if (run) pcnt_d = tick ? '0 : pcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q  <= '0;
      blink_q <= 1'b1;
    end else begin
      pcnt_q  <= pcnt_d;
      blink_q <= (pcnt_d < Half);
    end
  end

endmodule

// File: rtl/clock_timekeeper.sv
// 24-hour BCD clock with seconds prescaler and debounced-by-sync hour/minute set buttons.
module clock_timekeeper #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned CNT_W         = 27
) (
  input logic              clk,
  input logic              rst,
  clock_timekeeper_if.slave tk
);
  import clock_pkg::*;

  logic             tick, blink;
  logic [1:0]       sync1_q, sync2_q, prev_q, inc_q;
  logic             inc_h, inc_m;
  bcd_time_t        tod_q, tod_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             sec_tick_q;
  logic             min_carry, hour_carry;

  tick_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .CNT_W         (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .run   (tk.run),
    .tick  (tick),
    .blink (blink)
  );

  // Bit 1 = hour button, bit 0 = minute button; inc_q is registered to keep a 3-edge latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      inc_q   <= '0;
    end else begin
      sync1_q <= {tk.btn_hour, tk.btn_min};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      inc_q   <= sync2_q & ~prev_q;
    end
  end

  assign inc_h = inc_q[1];
  assign inc_m = inc_q[0];

  always_comb begin
    tod_d      = tod_q;
    sec_d      = sec_q;
    min_carry  = tick && (sec_q == SEC_MAX);
    // A manual minute bump swallows a coincident rollover so minutes move by exactly one.
    hour_carry = min_carry && !inc_m && min_at_max(tod_q);
    if (inc_m)     sec_d = '0;
    else if (tick) sec_d = min_carry ? '0 : sec_q + 6'd1;
    if (inc_m || min_carry)  tod_d = inc_min(tod_d);
    if (inc_h || hour_carry) tod_d = inc_hour(tod_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tod_q      <= '0;
      sec_q      <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      tod_q      <= tod_d;
      sec_q      <= sec_d;
      sec_tick_q <= tick;
    end
  end

  assign tk.hour1    = tod_q.hour1;
  assign tk.hour0    = tod_q.hour0;
  assign tk.min1     = tod_q.min1;
  assign tk.min0     = tod_q.min0;
  assign tk.sec_tick = sec_tick_q;
  assign tk.blink    = blink;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Self-checking bench: cycle-level time-of-day model plus directed corner cases and random buttons.
module tb_clock_timekeeper;

  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  clock_timekeeper_if tk ();

  clock_timekeeper #(
    .TICKS_PER_SEC (T),
    .CNT_W         (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tk  (tk)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_hhmm();
    return int'(tk.hour1) * 1000 + int'(tk.hour0) * 100 + int'(tk.min1) * 10 + int'(tk.min0);
  endfunction

  // Model: plain integers for h/m/s and prescaler count; buttons seen 3 edges late.
  int m_hh, m_mm, m_ss, m_pc;
  bit m_tick;
  bit hb[4];
  bit mb[4];

  always @(posedge clk) begin
    bit tk_now, ih, im, hc;
    if (!rst) begin
      m_hh = 0; m_mm = 0; m_ss = 0; m_pc = 0; m_tick = 0;
      for (int i = 0; i < 4; i++) begin hb[i] = 0; mb[i] = 0; end
    end else begin
      ih = hb[2] && !hb[3];
      im = mb[2] && !mb[3];
      for (int i = 3; i > 0; i--) begin hb[i] = hb[i-1]; mb[i] = mb[i-1]; end
      hb[0] = tk.btn_hour;
      mb[0] = tk.btn_min;
      tk_now = tk.run && (m_pc == T - 1);
      if (tk.run) m_pc = tk_now ? 0 : m_pc + 1;
      hc = 0;
      if (im) begin
        m_mm = (m_mm + 1) % 60;
        m_ss = 0;
      end else if (tk_now) begin
        if (m_ss == 59) begin
          m_ss = 0;
          if (m_mm == 59) begin m_mm = 0; hc = 1; end
          else m_mm++;
        end else m_ss++;
      end
      if (ih || hc) m_hh = (m_hh + 1) % 24;
      m_tick = tk_now;
    end
    #1;
    check("hour1", int'(tk.hour1), m_hh / 10);
    check("hour0", int'(tk.hour0), m_hh % 10);
    check("min1", int'(tk.min1), m_mm / 10);
    check("min0", int'(tk.min0), m_mm % 10);
    check("sec_tick", int'(tk.sec_tick), int'(m_tick));
    check("blink", int'(tk.blink), int'(m_pc < T / 2));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input bit run_after);
    @(negedge clk);
    tk.btn_hour = 0; tk.btn_min = 0;
    rst = 0;
    tk.run = run_after;
    cycles(2);
    rst = 1;
  endtask

  task automatic press(input bit h, input bit m);
    @(negedge clk);
    tk.btn_hour = h; tk.btn_min = m;
    cycles(3);
    tk.btn_hour = 0; tk.btn_min = 0;
    cycles(3);
  endtask

  task automatic preset(input int hh, input int mm);
    tk.run = 0;
    for (int i = 0; i < ((hh > mm) ? hh : mm); i++) press(i < hh, i < mm);
  endtask

  task automatic run_ticks(input int n);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < n * T + 20) begin
      @(posedge clk); #2;
      cyc++;
      if (tk.sec_tick) got++;
    end
    check("tick_count", got, n);
  endtask

  task automatic cycles_to_tick(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #2;
      cyc++;
    end while (!tk.sec_tick && cyc < 40);
  endtask

  // Leaves us at the negedge just before the edge that is 3 edges ahead of a 59 -> 0 tick.
  task automatic wait_sec59();
    int budget = 400;
    @(negedge clk);
    while (!(m_ss == 59 && m_pc == 0) && budget > 0) begin
      cycles(1);
      budget--;
    end
    check("sec59_reached", int'(budget > 0), 1);
  endtask

  initial begin
    int ticks, first, last, cyc;
    tk.run = 0; tk.btn_hour = 0; tk.btn_min = 0;

    // Free run from reset: 240 cycles = 60 seconds.
    do_reset(1'b1);
    ticks = 0; first = 0; last = 0;
    for (int c = 1; c <= 240; c++) begin
      @(posedge clk); #2;
      if (tk.sec_tick) begin
        if (ticks == 0) first = c;
        else check("tick_spacing", c - last, T);
        last = c;
        ticks++;
      end
    end
    check("ticks_in_240", ticks, 60);
    check("first_tick_cycle", first, T);
    check("time_after_240", dut_hhmm(), 1);

    // 23:59 rollover.
    do_reset(1'b0);
    preset(23, 59);
    check("preset_2359", dut_hhmm(), 2359);
    tk.run = 1;
    run_ticks(59);
    check("still_2359", dut_hhmm(), 2359);
    run_ticks(1);
    check("rollover_0000", dut_hhmm(), 0);

    // inc_m coinciding with the minute carry.
    do_reset(1'b0);
    preset(12, 34);
    tk.run = 1;
    wait_sec59();
    tk.btn_min = 1;
    cycles(3);
    tk.btn_min = 0;
    cycles(4);
    check("incm_with_carry", dut_hhmm(), 1235);
    run_ticks(59);
    check("secs_cleared", dut_hhmm(), 1235);
    run_ticks(1);
    check("next_minute", dut_hhmm(), 1236);

    // inc_h coinciding with the hour carry, then a long hold.
    do_reset(1'b0);
    preset(9, 59);
    tk.run = 1;
    wait_sec59();
    tk.btn_hour = 1;
    cycles(3);
    tk.btn_hour = 0;
    cycles(4);
    check("inch_with_carry", dut_hhmm(), 1000);
    tk.btn_hour = 1;
    cycles(100);
    tk.btn_hour = 0;
    cycles(5);
    check("held_button_once", dut_hhmm(), 1100);

    // Freeze at pcnt == 2.
    begin
      int budget = 20;
      @(negedge clk);
      while (m_pc != 2 && budget > 0) begin cycles(1); budget--; end
    end
    tk.run = 0;
    ticks = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #2;
      if (tk.sec_tick) ticks++;
    end
    check("frozen_ticks", ticks, 0);
    check("frozen_time", dut_hhmm(), 1100);
    @(negedge clk);
    tk.run = 1;
    cycles_to_tick(cyc);
    check("resume_tick_delay", cyc, 2);

    // Async reset between edges at 17:42.
    do_reset(1'b0);
    preset(17, 42);
    tk.run = 1;
    begin
      int budget = 20;
      @(negedge clk);
      while (!m_tick && budget > 0) begin cycles(1); budget--; end
    end
    check("pre_reset_time", dut_hhmm(), 1742);
    check("pre_reset_tick", int'(tk.sec_tick), 1);
    #2 rst = 0;
    #1;
    check("async_rst_time", dut_hhmm(), 0);
    check("async_rst_blink", int'(tk.blink), 1);
    check("async_rst_tick", int'(tk.sec_tick), 0);
    cycles(2);
    rst = 1;
    cycles_to_tick(cyc);
    check("first_tick_after_rst", cyc, T);

    // Random run/button activity against the model.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      tk.run = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) tk.btn_hour = ~tk.btn_hour;
      if ($urandom_range(0, 5) == 0) tk.btn_min = ~tk.btn_min;
    end
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
